// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared encodings for the load/store unit memory controller.
// Holds the size codes, FSM state constants, byte-mask constants and size helpers.
package lsu_mem_ctrl_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RD_WAIT = 2'd1;
  localparam logic [1:0] ST_WR      = 2'd2;
  localparam logic [1:0] ST_RESP    = 2'd3;

  localparam logic [7:0] MASK_B = 8'h01;
  localparam logic [7:0] MASK_H = 8'h03;
  localparam logic [7:0] MASK_W = 8'h0F;

  // The reserved size code 3 behaves as a word everywhere.
  function automatic logic [7:0] size_mask(input logic [1:0] sz);
    case (sz)
      SZ_B:    return MASK_B;
      SZ_H:    return MASK_H;
      SZ_W:    return MASK_W;
      default: return MASK_W;
    endcase
  endfunction

  function automatic logic [31:0] size_len(input logic [1:0] sz);
    case (sz)
      SZ_B:    return 32'd1;
      SZ_H:    return 32'd2;
      SZ_W:    return 32'd4;
      default: return 32'd4;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] lo);
    case (sz)
      SZ_B:    return 1'b0;
      SZ_H:    return lo[0];
      default: return (lo != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Combinational load-data extension: byte from bit 7, half from bit 15, word unchanged.
module lsu_load_ext
  import lsu_mem_ctrl_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] ext
);

  always_comb begin
    ext = raw;
    case (size)
      SZ_B:    ext = {{24{raw[7]  & ~is_unsigned}}, raw[7:0]};
      SZ_H:    ext = {{16{raw[15] & ~is_unsigned}}, raw[15:0]};
      default: ext = raw;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Single-outstanding load/store controller: latency load RD_LATENCY+1, store 2, misaligned 1.
// Requests are only accepted in IDLE; memory side has no backpressure.
module lsu_mem_ctrl
  import lsu_mem_ctrl_pkg::*;
#(
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_ren,
  output logic [31:0] mem_raddr,
  output logic [31:0] mem_rlen,
  input  logic [31:0] mem_rdata,
  output logic        mem_wen,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_wdata,
  output logic [7:0]  mem_wmask
);

  localparam logic [3:0] CNT_INIT = 4'(RD_LATENCY - 1);

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wen_q, wen_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [31:0] ext_dat;

  lsu_load_ext u_load_ext (
    .raw         (mem_rdata),
    .size        (size_q),
    .is_unsigned (uns_q),
    .ext         (ext_dat)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wen_d   = wen_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    uns_d   = uns_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          wen_d   = req_wen;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          size_d  = req_size;
          uns_d   = req_unsigned;
          cnt_d   = CNT_INIT;
          rdata_d = 32'h0;
          err_d   = 1'b0;
          if (misaligned(req_size, req_addr[1:0])) begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else if (req_wen) begin
            state_d = ST_WR;
          end else begin
            state_d = ST_RD_WAIT;
          end
        end
      end
      ST_RD_WAIT: begin
        // mem_rdata is only valid while mem_ren is high, so capture on the last wait cycle.
        if (cnt_q == 4'd0) begin
          rdata_d = ext_dat;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_WR:   state_d = ST_RESP;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      wen_q   <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      size_q  <= 2'd0;
      uns_q   <= 1'b0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Every memory-side output is forced to zero outside its own state.
  always_comb begin
    req_ready  = (state_q == ST_IDLE);
    mem_ren    = (state_q == ST_RD_WAIT);
    mem_wen    = (state_q == ST_WR);
    resp_valid = (state_q == ST_RESP);
    mem_raddr  = mem_ren ? addr_q : 32'h0;
    mem_rlen   = mem_ren ? size_len(size_q) : 32'h0;
    mem_waddr  = mem_wen ? {addr_q[31:2], 2'b00} : 32'h0;
    mem_wdata  = mem_wen ? (wdata_q << {addr_q[1:0], 3'b000}) : 32'h0;
    mem_wmask  = mem_wen ? (size_mask(size_q) << addr_q[1:0]) : 8'h00;
    resp_rdata = resp_valid ? rdata_q : 32'h0;
    resp_err   = resp_valid ? err_q : 1'b0;
  end

  logic unused_wen;
  assign unused_wen = wen_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Randomized scoreboard bench for lsu_mem_ctrl with a byte-arithmetic reference model.
module tb_lsu_mem_ctrl;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_wen, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_ren, mem_wen;
  logic [31:0] mem_raddr, mem_rlen, mem_rdata, mem_waddr, mem_wdata;
  logic [7:0]  mem_wmask;
  logic [31:0] cur_mem;

  always #5 clk = ~clk;

  assign mem_rdata = mem_ren ? cur_mem : 32'h0;

  lsu_mem_ctrl #(.RD_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rlen(mem_rlen), .mem_rdata(mem_rdata),
    .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          ren_n;
    int          wen_n;
    logic [31:0] raddr;
    logic [31:0] rlen;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [7:0]  wmask;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   inflight = 1'b0;
  int   lat = 0, ren_n = 0, wen_n = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: access width in bytes, alignment by modulo, extension by signed arithmetic.
  function automatic exp_t model(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [1:0] size, input logic uns, input logic [31:0] memv);
    exp_t   e;
    int     nb;
    int     off;
    longint v;
    longint full;
    e = '{default: 0};
    nb  = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    off = int'(addr[1:0]);
    if ((addr % nb) != 0) begin
      e.err = 1'b1;
      e.lat = 1;
    end else if (wen) begin
      e.lat   = 2;
      e.wen_n = 1;
      e.waddr = addr - 32'(off);
      e.wdata = wdata << (8 * off);
      e.wmask = 8'(((1 << nb) - 1) << off);
    end else begin
      e.lat   = LAT + 1;
      e.ren_n = LAT;
      e.raddr = addr;
      e.rlen  = 32'(nb);
      v = longint'(memv);
      if (nb < 4) begin
        full = longint'(1) << (8 * nb);
        v = v % full;
        if (!uns && v >= full / 2) v = v - full;
      end
      e.rdata = 32'(v);
    end
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q.delete();
      inflight = 1'b0;
    end else begin
      if (inflight) lat++;
      if (mem_ren) begin
        ren_n++;
        chk("ren_expected", 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) begin
          chk("mem_raddr", mem_raddr, q[0].raddr);
          chk("mem_rlen", mem_rlen, q[0].rlen);
        end
      end else begin
        chk("raddr_idle", mem_raddr, 32'h0);
        chk("rlen_idle", mem_rlen, 32'h0);
      end
      if (mem_wen) begin
        wen_n++;
        chk("wen_expected", 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) begin
          chk("mem_waddr", mem_waddr, q[0].waddr);
          chk("mem_wdata", mem_wdata, q[0].wdata);
          chk("mem_wmask", 32'(mem_wmask), 32'(q[0].wmask));
        end
      end else begin
        chk("waddr_idle", mem_waddr, 32'h0);
        chk("wdata_idle", mem_wdata, 32'h0);
        chk("wmask_idle", 32'(mem_wmask), 32'h0);
      end
      if (resp_valid) begin
        chk("ready_in_resp", 32'(req_ready), 32'd0);
        chk("resp_expected", 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("resp_rdata", resp_rdata, e.rdata);
          chk("resp_err", 32'(resp_err), 32'(e.err));
          chk("latency", 32'(lat), 32'(e.lat));
          chk("ren_cycles", 32'(ren_n), 32'(e.ren_n));
          chk("wen_cycles", 32'(wen_n), 32'(e.wen_n));
        end
        inflight = 1'b0;
      end
      if (req_valid && req_ready) begin
        inflight = 1'b1;
        lat = 0;
        ren_n = 0;
        wen_n = 0;
      end
    end
  end

  task automatic issue(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] size, input logic uns, input logic [31:0] memv);
    bit acc;
    bit accepted;
    q.push_back(model(wen, addr, wdata, size, uns, memv));
    cur_mem      = memv;
    req_wen      = wen;
    req_addr     = addr;
    req_wdata    = wdata;
    req_size     = size;
    req_unsigned = uns;
    req_valid    = 1'b1;
    accepted     = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      acc = req_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        accepted = 1'b1;
        break;
      end
    end
    req_valid    = 1'b0;
    req_wen      = 1'($urandom);
    req_addr     = $urandom;
    req_wdata    = $urandom;
    req_size     = 2'($urandom);
    req_unsigned = 1'($urandom);
    chk("accept_timeout", 32'(accepted), 32'd1);
    if (!accepted) q.delete();
  endtask

  task automatic wait_done();
    for (int i = 0; i < 60; i++) begin
      if (q.size() == 0) break;
      @(negedge clk);
    end
    chk("resp_timeout", 32'(q.size()), 32'd0);
    q.delete();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_wen = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    req_size = 2'd0; req_unsigned = 1'b0; cur_mem = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_mem_ren", 32'(mem_ren), 32'd0);
    chk("rst_mem_wen", 32'(mem_wen), 32'd0);

    issue(1'b0, 32'h8000_0004, 32'h0, 2'd2, 1'b0, 32'hDEAD_BEEF);        wait_done();
    issue(1'b0, 32'h8000_0003, 32'h0, 2'd0, 1'b0, 32'h0000_0080);        wait_done();
    issue(1'b0, 32'h8000_0003, 32'h0, 2'd0, 1'b1, 32'h0000_0080);        wait_done();
    issue(1'b1, 32'h8000_0002, 32'h0000_1234, 2'd1, 1'b0, $urandom);     wait_done();
    issue(1'b0, 32'h8000_0002, 32'h0, 2'd2, 1'b0, $urandom);             wait_done();
    issue(1'b1, 32'h8000_0001, 32'h0000_5678, 2'd1, 1'b0, $urandom);     wait_done();
    issue(1'b0, 32'h8000_0006, 32'h0, 2'd1, 1'b0, 32'h1234_8001);        wait_done();
    issue(1'b1, 32'h8000_0007, 32'hAABB_CCDD, 2'd0, 1'b0, $urandom);     wait_done();

    for (int n = 0; n < 300; n++) begin
      issue(1'($urandom), 32'h8000_0000 | ($urandom & 32'h0000_FFFF), $urandom,
            2'($urandom), 1'($urandom), $urandom);
      wait_done();
    end

    issue(1'b0, 32'h8000_0010, 32'h0, 2'd2, 1'b0, 32'hCAFE_F00D);
    @(posedge clk);
    #1;
    chk("abort_in_rd_wait", 32'(mem_ren), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_ready", 32'(req_ready), 32'd1);
    chk("abort_mem_ren", 32'(mem_ren), 32'd0);
    chk("abort_mem_wen", 32'(mem_wen), 32'd0);
    chk("abort_resp_valid", 32'(resp_valid), 32'd0);
    repeat (LAT + 3) @(posedge clk);
    #1;
    issue(1'b0, 32'h8000_0020, 32'h0, 2'd1, 1'b0, 32'h0000_9ABC);
    wait_done();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
